// File: rtl/vend_sequencer.sv
// Vending machine transaction sequencer: item select, coin collection,
// vend handshake and nickel-by-nickel change return.
module vend_sequencer #(
  parameter int PRICE1  = 15,
  parameter int PRICE2  = 25,
  parameter int PRICE3  = 30,
  parameter int PRICE4  = 35,
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] item_number,
  input  logic       select,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       cancel,
  input  logic       dispense_ack,
  output logic       dispense_req,
  output logic       nickel_out,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic       busy
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t          r_state;
  logic [5:0]      r_credit;
  logic [5:0]      r_price;
  logic [TW-1:0]   r_tmo;
  logic            r_dispense_req;
  logic            r_nickel_out;
  logic            r_coin_reject;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [5:0]      w_credit_nxt;
  logic [5:0]      w_price_nxt;
  logic [TW-1:0]   w_tmo_nxt;
  logic            w_reject;
  logic            w_nickel;
  logic            w_onehot;
  logic [5:0]      w_sel_price;
  logic            w_any_coin;

  assign w_any_coin = nickel_in | dime_in;

  // Decode the one-hot item select into its price; anything else is invalid.
  always_comb begin
    w_onehot    = 1'b1;
    w_sel_price = 6'd0;
    case (item_number)
      4'b0001: w_sel_price = 6'(PRICE1);
      4'b0010: w_sel_price = 6'(PRICE2);
      4'b0100: w_sel_price = 6'(PRICE3);
      4'b1000: w_sel_price = 6'(PRICE4);
      default: w_onehot    = 1'b0;
    endcase
  end

  // Next-state, credit bookkeeping and the pulse outputs for the next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_price_nxt  = r_price;
    w_tmo_nxt    = r_tmo;
    w_reject     = 1'b0;
    w_nickel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_reject = w_any_coin;
        if (select && w_onehot) begin
          w_price_nxt = w_sel_price;
          w_tmo_nxt   = '0;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          // Cancel wins over a coin in the same cycle; refund the full credit.
          w_reject    = w_any_coin;
          w_state_nxt = S_CHANGE;
        end else if (r_credit >= r_price) begin
          // Enough money already: refuse further coins so credit stays <= price+5.
          w_reject    = w_any_coin;
          w_state_nxt = S_VEND;
        end else if (nickel_in) begin
          w_credit_nxt = r_credit + 6'd5;
          w_reject     = dime_in;
          w_tmo_nxt    = '0;
        end else if (dime_in) begin
          w_credit_nxt = r_credit + 6'd10;
          w_tmo_nxt    = '0;
        end else if (r_tmo == TMO_MAX) begin
          w_state_nxt = S_CHANGE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_VEND: begin
        w_reject = w_any_coin;
        if (dispense_ack) begin
          w_credit_nxt = r_credit - r_price;
          w_state_nxt  = S_CHANGE;
        end
      end
      S_CHANGE: begin
        w_reject = w_any_coin;
        if (r_credit >= 6'd5) begin
          w_credit_nxt = r_credit - 6'd5;
          w_nickel     = 1'b1;
        end else begin
          w_credit_nxt = 6'd0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any credit without refund.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= 6'd0;
      r_price        <= 6'd0;
      r_tmo          <= '0;
      r_dispense_req <= 1'b0;
      r_nickel_out   <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_price        <= w_price_nxt;
      r_tmo          <= w_tmo_nxt;
      r_dispense_req <= (w_state_nxt == S_VEND);
      r_nickel_out   <= w_nickel;
      r_coin_reject  <= w_reject;
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  assign dispense_req = r_dispense_req;
  assign nickel_out   = r_nickel_out;
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus randomized transactions
// checked against a transaction-level money model.
module tb_vend_sequencer;

  localparam int TMO = 255;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] item_number;
  logic       select, nickel_in, dime_in, cancel, dispense_ack;
  logic       dispense_req, nickel_out, coin_reject, busy;
  logic [5:0] credit;

  int n_cmp = 0;
  int n_err = 0;
  int n_nick, n_rej, n_disp;

  vend_sequencer #(.PRICE1(15), .PRICE2(25), .PRICE3(30), .PRICE4(35), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .item_number(item_number), .select(select),
    .nickel_in(nickel_in), .dime_in(dime_in), .cancel(cancel),
    .dispense_ack(dispense_ack), .dispense_req(dispense_req),
    .nickel_out(nickel_out), .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (nickel_out)   n_nick++;
    if (coin_reject)  n_rej++;
    if (dispense_req) n_disp++;
  endtask

  task automatic clr_counts();
    n_nick = 0; n_rej = 0; n_disp = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_select(input logic [3:0] item);
    item_number = item; select = 1'b1;
    tick();
    select = 1'b0; item_number = 4'b0000;
  endtask

  // kind: 1 = nickel, 2 = dime, 3 = both
  task automatic coin(input int kind);
    nickel_in = kind[0]; dime_in = kind[1];
    tick();
    nickel_in = 1'b0; dime_in = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1; tick(); cancel = 1'b0;
  endtask

  task automatic pulse_ack();
    dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
  endtask

  task automatic wait_disp(input string tag, input int limit);
    int k = 0;
    while (!dispense_req && k < limit) begin tick(); k++; end
    chk(tag, dispense_req, 1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (busy && k < limit) begin tick(); k++; end
    chk(tag, busy, 0);
  endtask

  function automatic int price_of(input int idx);
    case (idx)
      0: return 15;
      1: return 25;
      2: return 30;
      default: return 35;
    endcase
  endfunction

  initial begin
    int price, model_credit, refund, kind;
    logic [3:0] item;
    bit cancelled;

    reset = 1'b1; item_number = 4'b0; select = 1'b0; nickel_in = 1'b0;
    dime_in = 1'b0; cancel = 1'b0; dispense_ack = 1'b0;
    clr_counts();
    tick(); tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", dispense_req, 0);
    chk("rst_nick", nickel_out, 0);
    chk("rst_rej", coin_reject, 0);
    reset = 1'b0;
    tick();

    // Exact-price purchase: 15c item paid with dime + nickel.
    clr_counts();
    do_select(4'b0001);
    chk("s1_busy", busy, 1);
    coin(2);
    chk("s1_credit10", credit, 10);
    coin(1);
    chk("s1_credit15", credit, 15);
    tick();
    chk("s1_disp_on", dispense_req, 1);
    tick(); tick();
    chk("s1_disp_hold", dispense_req, 1);
    pulse_ack();
    chk("s1_disp_off", dispense_req, 0);
    chk("s1_credit0", credit, 0);
    wait_idle("s1_idle", 5);
    chk("s1_no_change", n_nick, 0);

    // Overpay: 35c item with four dimes -> one nickel back.
    clr_counts();
    do_select(4'b1000);
    repeat (4) coin(2);
    chk("s2_credit40", credit, 40);
    wait_disp("s2_disp", 3);
    pulse_ack();
    chk("s2_credit5", credit, 5);
    wait_idle("s2_idle", 10);
    chk("s2_nicks", n_nick, 1);

    // Cancel with 20c: four consecutive nickels, no vend.
    clr_counts();
    do_select(4'b0010);
    coin(2); coin(2);
    chk("s3_credit20", credit, 20);
    pulse_cancel();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_nick_consec", nickel_out, 1);
    end
    chk("s3_credit0", credit, 0);
    wait_idle("s3_idle", 5);
    chk("s3_nicks", n_nick, 4);
    chk("s3_no_disp", n_disp, 0);

    // Timeout auto-refund after one nickel.
    clr_counts();
    do_select(4'b0100);
    coin(1);
    repeat (TMO - 5) tick();
    chk("s4_still_collect", credit, 5);
    chk("s4_no_early_refund", n_nick, 0);
    wait_idle("s4_idle", 30);
    chk("s4_nicks", n_nick, 1);
    chk("s4_no_disp", n_disp, 0);

    // Rejections, invalid select, stray ack, cancel ignored in VEND.
    clr_counts();
    coin(2);
    chk("s5_idle_rej", coin_reject, 1);
    chk("s5_idle_credit", credit, 0);
    do_select(4'b0011);
    chk("s5_bad_select", busy, 0);
    pulse_ack();
    chk("s5_stray_ack", busy, 0);
    do_select(4'b0001);
    coin(3);
    chk("s5_both_credit", credit, 5);
    chk("s5_both_rej", coin_reject, 1);
    cancel = 1'b1; nickel_in = 1'b1;
    tick();
    cancel = 1'b0; nickel_in = 1'b0;
    chk("s5_cancel_coin_rej", coin_reject, 1);
    chk("s5_cancel_credit", credit, 5);
    wait_idle("s5_cancel_idle", 10);
    do_select(4'b0001);
    coin(2); coin(1);
    wait_disp("s5_disp", 3);
    coin(1);
    chk("s5_vend_rej", coin_reject, 1);
    chk("s5_vend_credit", credit, 15);
    pulse_cancel();
    chk("s5_vend_cancel_ign", dispense_req, 1);
    pulse_ack();
    wait_idle("s5_idle", 5);

    // Reset in CHANGE with 20c discards the refund.
    clr_counts();
    do_select(4'b0010);
    coin(2); coin(2);
    pulse_cancel();
    chk("s6_change_credit", credit, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_busy", busy, 0);
    chk("s6_credit", credit, 0);
    repeat (6) tick();
    chk("s6_no_nicks", n_nick, 0);

    // Randomized transactions against a money-conservation model.
    for (int t = 0; t < 25; t++) begin
      int idx;
      clr_counts();
      idx = $urandom_range(0, 3);
      price = price_of(idx);
      item = 4'b0001 << idx;
      do_select(item);
      model_credit = 0;
      cancelled = 1'b0;
      while (model_credit < price) begin
        if ($urandom_range(0, 11) == 0) begin
          cancelled = 1'b1;
          break;
        end
        repeat ($urandom_range(0, 2)) tick();
        kind = $urandom_range(1, 3);
        coin(kind);
        model_credit += (kind == 2) ? 10 : 5;
        chk("rnd_credit", credit, model_credit);
      end
      if (cancelled) begin
        pulse_cancel();
        refund = model_credit;
      end else begin
        wait_disp("rnd_disp", 3);
        repeat ($urandom_range(0, 3)) tick();
        pulse_ack();
        refund = model_credit - price;
      end
      wait_idle("rnd_idle", 20);
      chk("rnd_refund", n_nick * 5, refund);
      chk("rnd_vend", (n_disp > 0) ? 1 : 0, cancelled ? 0 : 1);
      chk("rnd_final_credit", credit, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 The block SHALL have parameter PRICE1, default 15, price in cents of item 4'b0001.
REQ-002 The block SHALL have parameter PRICE2, default 25, price of item 4'b0010.
REQ-003 The block SHALL have parameter PRICE3, default 30, price of item 4'b0100.
REQ-004 The block SHALL have parameter PRICE4, default 35, price of item 4'b1000.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, idle cycles in COLLECT before auto-refund.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-008 The block SHALL have port item_number, input, 4 bits, one-hot item select.
REQ-009 The block SHALL have port select, input, 1 bit, a 1-cycle pulse that latches item_number.
REQ-010 The block SHALL have ports nickel_in and dime_in, inputs, 1 bit each, 1-cycle coin pulses.
REQ-011 The block SHALL have port cancel, input, 1 bit, a customer refund request.
REQ-012 The block SHALL have port dispense_ack, input, 1 bit, pulsed by the dispense mechanism when it completes.
REQ-013 The block SHALL have port dispense_req, output, 1 bit, the vend request, held until acknowledged.
REQ-014 The block SHALL have port nickel_out, output, 1 bit, with one pulse per nickel returned.
REQ-015 The block SHALL have port coin_reject, output, 1 bit, a pulse for a coin not credited.
REQ-016 The block SHALL have port credit, output, 6 bits, the current credit in cents.
REQ-017 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-018 All outputs SHALL be registered.

Function
REQ-019 The FSM SHALL have states IDLE, COLLECT, VEND and CHANGE.
REQ-020 In IDLE, select with a valid one-hot item_number SHALL latch that item's price and enter COLLECT next cycle.
REQ-021 In IDLE, select with a non-one-hot item_number SHALL be ignored.
REQ-022 In IDLE, any coin pulse SHALL produce coin_reject=1 the next cycle, with credit unchanged.
REQ-023 In COLLECT, nickel_in SHALL add 5 to credit and dime_in SHALL add 10, visible on credit the next cycle.
REQ-024 If nickel_in and dime_in are both high in the same cycle, the nickel SHALL be credited and the dime rejected.
REQ-025 In COLLECT, once registered credit >= latched price, the FSM SHALL enter VEND on the following edge.
REQ-026 In COLLECT, cancel SHALL move the FSM to CHANGE with refund = full credit.
REQ-027 If cancel and a coin arrive in the same cycle, cancel SHALL win and the coin SHALL be rejected.
REQ-028 The COLLECT timeout counter SHALL clear on entry to COLLECT and on every credited coin.
REQ-029 When the timeout counter reaches TIMEOUT, the FSM SHALL enter CHANGE as if cancel had been asserted.
REQ-030 In VEND, dispense_req SHALL be 1 from the first VEND cycle until the cycle after dispense_ack is sampled.
REQ-031 In VEND, coins SHALL be rejected and cancel SHALL be ignored.
REQ-032 On dispense_ack, credit SHALL become credit minus price and the FSM SHALL enter CHANGE.
REQ-033 In CHANGE, each cycle with credit >= 5 SHALL produce a nickel_out pulse and decrement credit by 5.
REQ-034 In CHANGE, a cycle with credit == 0 SHALL return the FSM to IDLE.
REQ-035 In CHANGE, coins SHALL be rejected.
REQ-036 Credit SHALL never exceed price+5 (maximum 40 with defaults) and SHALL never wrap.
REQ-037 dispense_ack outside VEND SHALL be ignored.

Reset
REQ-038 On reset, the FSM SHALL go to IDLE, with credit=0, latched price=0 and timeout counter=0.
REQ-039 On reset, dispense_req, nickel_out, coin_reject and busy SHALL all be 0.
REQ-040 Reset asserted mid-transaction (any state) SHALL discard credit with no refund pulses and SHALL take priority over all inputs.

Verification
REQ-041 The bench SHALL cover: select 4'b0001, then dime and nickel -> credit 10 then 15; VEND; dispense_req until ack; no nickel_out; IDLE.
REQ-042 The bench SHALL cover: select 4'b1000 (35), then four dimes -> credit 40; VEND; after ack, exactly 1 nickel_out pulse; IDLE.
REQ-043 The bench SHALL cover: select 4'b0010, then dime and dime, then cancel -> 4 consecutive nickel_out pulses, credit 0, IDLE, no dispense_req.
REQ-044 The bench SHALL cover: select 4'b0100, then one nickel, then TIMEOUT idle cycles -> 1 nickel_out pulse; IDLE.
REQ-045 The bench SHALL cover: simultaneous nickel_in and dime_in in COLLECT -> credit +5 and coin_reject=1; a coin in IDLE or VEND -> coin_reject=1.
REQ-046 The bench SHALL cover: reset during CHANGE with credit 20 -> next cycle IDLE, credit 0, no further nickel_out.
